// File: rtl/p2s_serializer_with_sig.sv
// p2s_serializer_with_sig: pops one FIFO word, waits out the pipeline latency, then shifts it out MSB-first
// on a 1-bit valid/ready stream with first/last framing; width and latency are runtime-configurable.
module p2s_serializer_with_sig #(
    parameter int max_FIFO_WIDTH = 11,
    parameter int max_NUM_LOOPS  = 6
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              empty,
    output logic                              pop,
    input  logic [max_FIFO_WIDTH-1:0]         pop_data,
    input  logic [$clog2(max_FIFO_WIDTH):0]   sig_FIFO_WIDTH,
    input  logic [$clog2(max_NUM_LOOPS):0]    sig_NUM_LOOPS,
    input  logic                              ser_ready,
    output logic                              ser_valid,
    output logic                              ser_data,
    output logic                              ser_first,
    output logic                              ser_last,
    output logic                              busy
);
    localparam int WW = $clog2(max_FIFO_WIDTH) + 1;
    localparam int NW = $clog2(max_NUM_LOOPS) + 1;
    localparam int BW = WW - 1;

    typedef enum logic [1:0] {IDLE, POP, WAIT, SHIFT} state_t;

    state_t                    state, nxt;
    logic [WW-1:0]             cfg_w, w_eff;
    logic [NW-1:0]             cfg_n, n_eff, wait_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [max_FIFO_WIDTH-1:0] shreg, mask;

    assign w_eff = sig_FIFO_WIDTH == '0 ? WW'(1) :
                   sig_FIFO_WIDTH > WW'(max_FIFO_WIDTH) ? WW'(max_FIFO_WIDTH) : sig_FIFO_WIDTH;
    assign n_eff = sig_NUM_LOOPS == '0 ? NW'(1) :
                   sig_NUM_LOOPS > NW'(max_NUM_LOOPS) ? NW'(max_NUM_LOOPS) : sig_NUM_LOOPS;

    always_comb begin
        mask = '0;
        for (int i = 0; i < max_FIFO_WIDTH; i++) mask[i] = WW'(i) < cfg_w;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = empty ? IDLE : POP;
            POP:     nxt = WAIT;
            WAIT:    nxt = wait_cnt == cfg_n ? SHIFT : WAIT;
            SHIFT:   nxt = (ser_ready && bit_cnt == '0) ? IDLE : SHIFT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_w    <= '0;
            cfg_n    <= '0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                POP: begin
                    cfg_w    <= w_eff;
                    cfg_n    <= n_eff;
                    wait_cnt <= NW'(1);
                end
                WAIT: begin
                    if (wait_cnt == cfg_n) begin
                        shreg   <= pop_data & mask;
                        bit_cnt <= BW'(cfg_w - WW'(1));
                    end else begin
                        wait_cnt <= wait_cnt + NW'(1);
                    end
                end
                SHIFT: if (ser_ready && bit_cnt != '0) bit_cnt <= bit_cnt - BW'(1);
                default: ;
            endcase
        end
    end

    // every output is a decode of registered state, never of an input
    assign pop       = state == POP;
    assign busy      = state != IDLE;
    assign ser_valid = state == SHIFT;
    assign ser_data  = ser_valid & shreg[bit_cnt];
    assign ser_first = ser_valid && ({1'b0, bit_cnt} == cfg_w - WW'(1));
    assign ser_last  = ser_valid && bit_cnt == '0;
endmodule

// File: tb/tb_p2s_serializer_with_sig.sv
// tb_p2s_serializer_with_sig: directed vectors against a small FIFO/pipeline model with hand-computed expectations.
module tb_p2s_serializer_with_sig;
    logic        clk = 0, rstn = 0, ser_ready = 1;
    logic        pop, ser_valid, ser_data, ser_first, ser_last, busy, empty;
    logic [10:0] pop_data, word = 11'h0;
    logic [4:0]  sig_FIFO_WIDTH = 5'd8;
    logic [3:0]  sig_NUM_LOOPS  = 4'd1;
    int          pushed = 0, popped = 0, dcnt = 0, m_n = 1, cyc = 0;
    int          vectors = 0, errors = 0;

    p2s_serializer_with_sig dut (
        .clk(clk), .rstn(rstn), .empty(empty), .pop(pop), .pop_data(pop_data),
        .sig_FIFO_WIDTH(sig_FIFO_WIDTH), .sig_NUM_LOOPS(sig_NUM_LOOPS),
        .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_data(ser_data),
        .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: word is valid on pop_data only in cycle P+N, garbage otherwise
    assign empty    = pushed == popped;
    assign pop_data = dcnt == 1 ? word : ~word;
    always @(posedge clk) if (rstn && pop) popped <= popped + 1;
    always @(posedge clk or negedge rstn)
        if (!rstn)         dcnt <= 0;
        else if (pop)      dcnt <= m_n;
        else if (dcnt != 0) dcnt <= dcnt - 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input int w, input int n, input logic [10:0] d, input int nw,
                       input int exp_nb, input logic [31:0] exp_val, input int exp_lat,
                       input int stall_at, input int chg_at, input int exp_space);
        int npop = 0, nb = 0, pc1 = -1, pc2 = -1, vc = -1, ferr = 0, herr = 0, stall = 0, wb, k;
        logic [31:0] acc = 0;
        logic held = 0;
        sig_FIFO_WIDTH = 5'(w);
        sig_NUM_LOOPS  = 4'(n);
        word = d;
        m_n = exp_lat - 1;
        ser_ready = 1;
        wb = exp_nb / nw;
        pushed += nw;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pop) begin
                npop++;
                if (pc1 < 0) pc1 = cyc; else pc2 = cyc;
            end
            if (ser_valid && vc < 0) vc = cyc;
            if (ser_valid && ser_ready) begin
                if (ser_first != (nb % wb == 0) || ser_last != (nb % wb == wb - 1)) ferr++;
                acc = {acc[30:0], ser_data};
                nb++;
                if (nb == stall_at) begin
                    ser_ready = 0;
                    stall = 3;
                    held = exp_val[exp_nb - 1 - nb];
                end
                if (nb == chg_at) sig_FIFO_WIDTH = 5'd3;
            end else if (stall > 0) begin
                if (!ser_valid || ser_data !== held) herr++;
                stall--;
                if (stall == 0) ser_ready = 1;
            end
            if (nb >= exp_nb && npop >= nw && !busy) break;
        end
        chk({tag, " timeout"}, k == 300, 0);
        chk({tag, " pops"}, npop, nw);
        chk({tag, " nbits"}, nb, exp_nb);
        chk({tag, " data"}, acc, exp_val);
        chk({tag, " latency"}, vc - pc1, exp_lat);
        chk({tag, " framing"}, ferr, 0);
        chk({tag, " hold"}, herr, 0);
        chk({tag, " busy_end"}, busy, 0);
        if (nw > 1) chk({tag, " spacing"}, pc2 - pc1, exp_space);
    endtask

    initial begin
        int bad, k;
        #3;
        chk("reset outputs", {pop, ser_valid, ser_data, ser_first, ser_last, busy}, 0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        run("basic", 8, 3, 11'h0A5, 1, 8, 32'hA5, 4, 0, 0, 0);
        run("mask", 4, 1, 11'h7FF, 1, 4, 32'hF, 2, 0, 0, 0);
        run("backpressure", 8, 2, 11'h03C, 1, 8, 32'h3C, 3, 1, 0, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pop || busy) bad++;
        end
        chk("empty idle", bad, 0);
        run("b2b", 11, 6, 11'h5A3, 2, 22, 32'h2D1DA3, 7, 0, 0, 19);
        run("n_zero", 8, 0, 11'h096, 1, 8, 32'h96, 2, 0, 0, 0);
        run("w_zero", 0, 2, 11'h7FF, 1, 1, 32'h1, 3, 0, 0, 0);
        run("w_n_max", 15, 9, 11'h6B5, 1, 11, 32'h6B5, 7, 0, 0, 0);
        run("cfg_change", 8, 2, 11'h0C3, 1, 8, 32'hC3, 3, 0, 3, 0);

        sig_FIFO_WIDTH = 5'd11;
        sig_NUM_LOOPS  = 4'd1;
        word = 11'h5A5;
        m_n = 1;
        ser_ready = 1;
        pushed++;
        for (k = 0; k < 50 && !ser_valid; k++) @(negedge clk);
        chk("rst_mid reach shift", ser_valid, 1);
        repeat (4) @(negedge clk);
        rstn = 0;
        #1;
        chk("rst_mid outputs", {pop, ser_valid, ser_data, ser_first, ser_last, busy}, 0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("rst_mid idle", {pop, busy}, 0);
        pushed++;
        @(negedge clk);
        chk("rst_mid pop", pop, 1);
        for (k = 0; k < 50 && busy; k++) @(negedge clk);
        chk("rst_mid done", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
